// File: rtl/chacha_pkg.sv
// Shared types, constants and quarter-round word tables for the ChaCha block engine.
package chacha_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam word_t CHACHA_SIGMA [4] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    // [parity][qr][a,b,c,d]: parity 0 = column round, 1 = diagonal round
    localparam logic [3:0] QR_IDX [2][4][4] = '{
        '{'{4'd0, 4'd4, 4'd8,  4'd12},
          '{4'd1, 4'd5, 4'd9,  4'd13},
          '{4'd2, 4'd6, 4'd10, 4'd14},
          '{4'd3, 4'd7, 4'd11, 4'd15}},
        '{'{4'd0, 4'd5, 4'd10, 4'd15},
          '{4'd1, 4'd6, 4'd11, 4'd12},
          '{4'd2, 4'd7, 4'd8,  4'd13},
          '{4'd3, 4'd4, 4'd9,  4'd14}}
    };

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_block_engine_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr_core
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_new,
    output word_t b_new,
    output word_t c_new,
    output word_t d_new
);

    word_t a1, b1, c1, d1;

    assign a1    = a + b;
    assign d1    = rotl(d ^ a1, 16);
    assign c1    = c + d1;
    assign b1    = rotl(b ^ c1, 12);
    assign a_new = a1 + b1;
    assign d_new = rotl(d1 ^ a_new, 8);
    assign c_new = c1 + d_new;
    assign b_new = rotl(b1 ^ c_new, 7);

endmodule

// File: rtl/chacha_block_engine.sv
// Iterative ChaCha block function: QR_PAR quarter-rounds per cycle, ROUNDS rounds,
// final feed-forward add of the original state. Handshaked input and output.
module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int QR_PAR = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    localparam int STEPS  = 4 / QR_PAR;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int RND_W  = $clog2(ROUNDS);

    if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be even and >= 2");
    end
    if (QR_PAR != 1 && QR_PAR != 2 && QR_PAR != 4) begin : g_bad_par
        $error("chacha_block_engine: QR_PAR must be 1, 2 or 4");
    end

    state_t             state, state_next;
    logic [RND_W-1:0]   round_cnt;
    logic [STEP_W-1:0]  step_cnt;
    word_t              working  [16];
    word_t              original [16];
    word_t              mixed    [16];
    word_t              ra [QR_PAR], rb [QR_PAR], rc [QR_PAR], rd [QR_PAR];
    logic [3:0]         ia [QR_PAR], ib [QR_PAR], ic [QR_PAR], id [QR_PAR];
    logic               accept, last_step, step_wrap;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready depends only on state and out_ready so a DONE block can hand over same-cycle.
    assign in_ready  = reset && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == ROUND);
    assign step_wrap = (step_cnt == STEP_W'(STEPS - 1));
    assign last_step = (state == ROUND) && step_wrap && (round_cnt == RND_W'(ROUNDS - 1));

    for (genvar p = 0; p < QR_PAR; p++) begin : g_qr
        logic [1:0] slot;
        assign slot  = 2'(int'(step_cnt) * QR_PAR + p);
        assign ia[p] = QR_IDX[round_cnt[0]][slot][0];
        assign ib[p] = QR_IDX[round_cnt[0]][slot][1];
        assign ic[p] = QR_IDX[round_cnt[0]][slot][2];
        assign id[p] = QR_IDX[round_cnt[0]][slot][3];

        chacha_qr_core u_qr (
            .a     (working[ia[p]]),
            .b     (working[ib[p]]),
            .c     (working[ic[p]]),
            .d     (working[id[p]]),
            .a_new (ra[p]),
            .b_new (rb[p]),
            .c_new (rc[p]),
            .d_new (rd[p])
        );
    end

    // QRs within one set touch disjoint words, so write-back order does not matter.
    always_comb begin
        for (int i = 0; i < 16; i++) mixed[i] = working[i];
        for (int p = 0; p < QR_PAR; p++) begin
            mixed[ia[p]] = ra[p];
            mixed[ib[p]] = rb[p];
            mixed[ic[p]] = rc[p];
            mixed[id[p]] = rd[p];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROUND;
            ROUND:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = in_valid ? ROUND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round_cnt <= '0;
            step_cnt  <= '0;
            out_block <= '0;
            for (int i = 0; i < 16; i++) begin
                working[i]  <= '0;
                original[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                round_cnt <= '0;
                step_cnt  <= '0;
                for (int i = 0; i < 16; i++) begin
                    working[i]  <= in_state[32*i +: 32];
                    original[i] <= in_state[32*i +: 32];
                end
            end else if (state == ROUND) begin
                for (int i = 0; i < 16; i++) working[i] <= mixed[i];
                if (step_wrap) begin
                    step_cnt  <= '0;
                    round_cnt <= round_cnt + 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
                if (last_step) begin
                    for (int i = 0; i < 16; i++)
                        out_block[32*i +: 32] <= mixed[i] + original[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Self-checking bench for chacha_block_engine against a software ChaCha block model.
module tb_chacha_block_engine;
    import chacha_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [511:0] in_state, out_block;

    logic         alt_valid;
    logic [511:0] alt_state, zero_state;
    logic         q1_in_ready, q1_out_valid, q1_busy;
    logic         q2_in_ready, q2_out_valid, q2_busy;
    logic         r8_in_ready, r8_out_valid, r8_busy;
    logic [511:0] q1_block, q2_block, r8_block;

    word_t qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;

    int checks = 0;
    int errors = 0;

    chacha_block_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .busy(busy));

    chacha_block_engine #(.ROUNDS(20), .QR_PAR(1)) dut_q1 (
        .clk(clk), .reset(reset), .in_valid(alt_valid), .in_ready(q1_in_ready),
        .in_state(alt_state), .out_valid(q1_out_valid), .out_ready(1'b1),
        .out_block(q1_block), .busy(q1_busy));

    chacha_block_engine #(.ROUNDS(20), .QR_PAR(2)) dut_q2 (
        .clk(clk), .reset(reset), .in_valid(alt_valid), .in_ready(q2_in_ready),
        .in_state(alt_state), .out_valid(q2_out_valid), .out_ready(1'b1),
        .out_block(q2_block), .busy(q2_busy));

    chacha_block_engine #(.ROUNDS(8), .QR_PAR(4)) dut_r8 (
        .clk(clk), .reset(reset), .in_valid(alt_valid), .in_ready(r8_in_ready),
        .in_state(zero_state), .out_valid(r8_out_valid), .out_ready(1'b1),
        .out_block(r8_block), .busy(r8_busy));

    chacha_qr_core u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_new(qa_n), .b_new(qb_n), .c_new(qc_n), .d_new(qd_n));

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_m(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rol(d ^ a, 16);
        c = c + d; b = rol(b ^ c, 12);
        a = a + b; d = rol(d ^ a, 8);
        c = c + d; b = rol(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] block_m(input logic [511:0] s, input int rounds);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int n = 0; n < rounds; n += 2) begin
            {x[0], x[4], x[8],  x[12]} = qr_m(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr_m(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr_m(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr_m(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr_m(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr_m(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr_m(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr_m(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- checks ----------------
    task automatic check_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_main(input logic [511:0] s, output int lat);
        @(negedge clk);
        in_state = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic consume_main();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_bit("consume_out_valid", out_valid, 1'b0);
    endtask

    logic [31:0]  rfc_in_w  [16];
    logic [31:0]  rfc_out_w [16];
    logic [511:0] rfc_state, rfc_exp, s1, s2, held;
    int           lat, cyc, lat_q1, lat_q2, lat_r8;
    logic [511:0] blk_q1, blk_q2, blk_r8;
    logic         stable_ok;

    initial begin
        rfc_in_w = '{CHACHA_SIGMA[0], CHACHA_SIGMA[1], CHACHA_SIGMA[2], CHACHA_SIGMA[3],
                     32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                     32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                     32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        rfc_out_w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        for (int i = 0; i < 16; i++) begin
            rfc_state[32*i +: 32] = rfc_in_w[i];
            rfc_exp[32*i +: 32]   = rfc_out_w[i];
        end

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        alt_valid = 1'b0; alt_state = '0; zero_state = '0;
        qa = '0; qb = '0; qc = '0; qd = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_vec("rst_out_block", out_block, '0);
        reset = 1'b1;
        #1 check_bit("idle_in_ready", in_ready, 1'b1);

        // standalone quarter-round vector
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1 check_vec("qr_core", {384'd0, qa_n, qb_n, qc_n, qd_n},
                     {384'd0, 32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb});

        // RFC block at defaults
        send_main(rfc_state, lat);
        check_int("rfc_latency", lat, 20);
        check_vec("rfc_block", out_block, rfc_exp);
        consume_main();

        // QR_PAR=1/2 with the RFC state, ROUNDS=8 with an all-zero state
        @(negedge clk);
        alt_state = rfc_state;
        alt_valid = 1'b1;
        @(posedge clk);
        #1 alt_valid = 1'b0;
        lat_q1 = -1; lat_q2 = -1; lat_r8 = -1;
        blk_q1 = '0; blk_q2 = '0; blk_r8 = '0;
        cyc = 0;
        while ((lat_q1 < 0 || lat_q2 < 0 || lat_r8 < 0) && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            if (lat_q1 < 0 && q1_out_valid) begin lat_q1 = cyc; blk_q1 = q1_block; end
            if (lat_q2 < 0 && q2_out_valid) begin lat_q2 = cyc; blk_q2 = q2_block; end
            if (lat_r8 < 0 && r8_out_valid) begin lat_r8 = cyc; blk_r8 = r8_block; end
        end
        check_int("q1_latency", lat_q1, 80);
        check_vec("q1_block", blk_q1, rfc_exp);
        check_int("q2_latency", lat_q2, 40);
        check_vec("q2_block", blk_q2, rfc_exp);
        check_int("r8_latency", lat_r8, 8);
        check_vec("r8_zero_block", blk_r8, block_m('0, 8));

        // all-zero input at 20 rounds
        send_main('0, lat);
        check_vec("zero20_block", out_block, block_m('0, 20));
        consume_main();

        // backpressure: hold the result for 10 cycles
        s1 = rand_state();
        send_main(s1, lat);
        check_int("bp_latency", lat, 20);
        check_vec("bp_block", out_block, block_m(s1, 20));
        held = out_block;
        stable_ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 if (out_block !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        check_bit("bp_stable", stable_ok, 1'b1);

        // back-to-back release; in_valid raised mid-ROUND must be ignored
        s2 = rand_state();
        @(negedge clk);
        in_state = s2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check_bit("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 begin in_valid = 1'b0; out_ready = 1'b0; end
        check_bit("b2b_busy", busy, 1'b1);
        check_bit("b2b_out_valid", out_valid, 1'b0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 3) begin
                in_valid = 1'b1;
                in_state = ~s2;
                check_bit("round_in_ready", in_ready, 1'b0);
            end
        end
        in_valid = 1'b0;
        check_int("b2b_latency", lat, 20);
        check_vec("b2b_block", out_block, block_m(s2, 20));
        consume_main();

        // reset in the middle of a block
        @(negedge clk);
        in_state = rand_state();
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1 begin
            check_bit("midrst_out_valid", out_valid, 1'b0);
            check_bit("midrst_busy", busy, 1'b0);
            check_bit("midrst_in_ready", in_ready, 1'b0);
            check_vec("midrst_out_block", out_block, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1 check_bit("midrst_release_ready", in_ready, 1'b1);
        send_main(rfc_state, lat);
        check_int("post_rst_latency", lat, 20);
        check_vec("post_rst_block", out_block, rfc_exp);
        consume_main();

        // random blocks
        for (int k = 0; k < 3; k++) begin
            s1 = rand_state();
            send_main(s1, lat);
            check_int("rand_latency", lat, 20);
            check_vec("rand_block", out_block, block_m(s1, 20));
            consume_main();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
